data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum clk cycles spent in any memory wait state before the transaction is aborted; legal range 4..65535.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Ports: p0_req / p1_req  input  1  requester N has a pending transaction; held high with its fields stable until pN_ack.
REQ-005 Ports: p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-006 Ports: p0_addr / p1_addr  input  64  byte address.
REQ-007 Ports: p0_size / p1_size  input  2  block size code, passed to memory unmodified.
REQ-008 Ports: p0_wdata / p1_wdata  input  64  write data.
REQ-009 Ports: p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-010 Ports: p0_err / p1_err  output  1  valid with ack; 1 = timed out.
REQ-011 Ports: p0_rdata / p1_rdata  output  64  read result, held until that port's next ack.
REQ-012 Ports: mem_read_request, mem_write_request  output  1  level requests to the data memory.
REQ-013 Ports: mem_address 64, mem_block_size 2, mem_write_data 64  output  command fields.
REQ-014 Ports: mem_read_ready, mem_write_ready, mem_write_finished  input  1  asynchronous response pulses, each high for at least one clk period.
REQ-015 Port: mem_read_data  input  64  read data, valid while mem_read_request is high.
REQ-016 Ports: busy  output  1  state != IDLE; grant_id  output  1  port owning the current transaction.

Function
REQ-017 Each mem response input passes through a 2-flop synchronizer plus a rising-edge detector; only detected edges are acted on.
REQ-018 States: IDLE, WAIT_RD, WAIT_WR_READY, WAIT_WR_DONE, DONE.
REQ-019 IDLE: if any pN_req is high, grant one port. Latch its we/addr/size/wdata into the mem_* registers and set grant_id. Next state: WAIT_RD when we=0, WAIT_WR_READY when we=1.
REQ-020 Arbitration is round-robin: when both requests are high, the port not granted last wins. The last-grant register resets to 1, so port 0 wins the first contention.
REQ-021 mem_read_request / mem_write_request are registered. They rise on the clock edge that leaves IDLE and stay high until that transaction leaves its wait states. They are never high together.
REQ-022 WAIT_RD, on a read_ready edge: capture mem_read_data into pN_rdata, drop mem_read_request, go to DONE.
REQ-023 WAIT_WR_READY, on a write_ready edge: go to WAIT_WR_DONE, keeping mem_write_request high.
REQ-024 WAIT_WR_DONE, on a write_finished edge: drop mem_write_request, go to DONE.
REQ-025 Edges on response inputs that do not match the current state are discarded.
REQ-026 A 16-bit wait counter clears on entry to each wait state and increments every cycle spent there.
REQ-027 When the counter reaches TIMEOUT_CYCLES: drop both requests, set pN_err=1, leave pN_rdata unchanged, go to DONE.
REQ-028 DONE lasts exactly one cycle: pN_ack=1 for the granted port only, err valid alongside it; then go to IDLE.
- Guarantees at least one low cycle between consecutive memory requests.
- Requests arriving during DONE are first evaluated in IDLE.
REQ-029 A pN_req that falls before its ack is a protocol violation; the transaction still completes and its ack is still issued.
REQ-030 System constraint: TIMEOUT_CYCLES exceeds the worst-case memory latency plus 3 cycles. A response arriving after a timeout is not attributed to any transaction.

Reset
REQ-031 While reset is high:
- state = IDLE; all mem_* outputs, pN_ack, pN_err, pN_rdata, busy, grant_id = 0.
- Synchronizers, edge detectors and wait counter cleared; last-grant register = 1.
REQ-032 Reset asserted mid-transaction immediately drops any memory request; no ack is generated for the aborted transaction.

Verification
REQ-033 Single read: p0 reads addr 0x100, memory responds with 0xDEADBEEF after 20 ns -> mem_read_request high from the cycle after the request until the edge is detected; p0_ack pulses once; p0_rdata = 0xDEADBEEF; p0_err = 0.
REQ-034 Single write: p1 writes 0x55AA to addr 0x40, size 2'b11 -> write_ready then write_finished both observed; p1_ack pulses once, only after the write_finished edge; mem_read_request stays 0 throughout.
REQ-035 Contention: p0 and p1 both request in the same cycle after reset, for 3 back-to-back transactions each -> grant order 0,1,0,1,0,1; at least one cycle with both mem requests low between transactions.
REQ-036 Timeout: TIMEOUT_CYCLES=8, memory never responds -> mem request drops 8 cycles after wait entry; ack with err=1 and rdata unchanged; the next request is then served normally.
REQ-037 Reset mid-operation: reset asserted in WAIT_WR_DONE -> all outputs 0 asynchronously, no ack; after release a new read completes correctly.
REQ-038 Stray pulse: mem_write_ready pulsed while in WAIT_RD -> ignored; the read still completes on the read_ready edge.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter_if
// Bundles the two requester ports and the data-memory command/response bus
// seen by data_memory_arbiter.
//   p0_* / p1_*   : requester handshake (req/we/addr/size/wdata in,
//                   ack/err/rdata out)
//   mem_* command : read/write level requests plus address, size, write data
//   mem_* response: read_ready / write_ready / write_finished pulses (async to
//                   clk) and read data
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)
// -----------------------------------------------------------------------------
interface data_memory_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [63:0] p0_addr;
    logic [1:0]  p0_size;
    logic [63:0] p0_wdata;
    logic        p0_ack;
    logic        p0_err;
    logic [63:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [63:0] p1_addr;
    logic [1:0]  p1_size;
    logic [63:0] p1_wdata;
    logic        p1_ack;
    logic        p1_err;
    logic [63:0] p1_rdata;

    logic        mem_read_request;
    logic        mem_write_request;
    logic [63:0] mem_address;
    logic [1:0]  mem_block_size;
    logic [63:0] mem_write_data;
    logic        mem_read_ready;
    logic        mem_write_ready;
    logic        mem_write_finished;
    logic [63:0] mem_read_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_size, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_size, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_read_request, mem_write_request, mem_address,
               mem_block_size, mem_write_data,
        input  mem_read_ready, mem_write_ready, mem_write_finished, mem_read_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_size, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_size, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_read_request, mem_write_request, mem_address,
               mem_block_size, mem_write_data,
        output mem_read_ready, mem_write_ready, mem_write_finished, mem_read_data
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
// Two-port round-robin arbiter in front of a single data memory whose
// response strobes are asynchronous to clk. One transaction is in flight at a
// time; each memory wait state is bounded by TIMEOUT_CYCLES, after which the
// transaction completes with err=1.
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous, active-high
//   bus      - data_memory_arbiter_if.slave (requesters + memory bus)
//   busy     - high whenever the FSM is not IDLE
//   grant_id - port that owns the current transaction
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_arbiter_if.slave        bus,
    output logic                        busy,
    output logic                        grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RD,
        WAIT_WR_READY,
        WAIT_WR_DONE,
        DONE
    } state_t;

    // Bit positions of the three memory response strobes.
    localparam int RD = 0;
    localparam int WR = 1;
    localparam int WF = 2;

    state_t      state;
    logic        last_grant;
    logic [15:0] wait_cnt;

    logic [2:0]  resp_async;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  sync_prev;
    logic [2:0]  resp_edge;

    logic        grant_sel;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [1:0]  sel_size;
    logic [63:0] sel_wdata;
    logic        timeout_hit;

    assign resp_async = {bus.mem_write_finished, bus.mem_write_ready, bus.mem_read_ready};
    assign resp_edge  = sync2 & ~sync_prev;

    // The counter value after this cycle's increment is what gets compared, so
    // the request is dropped exactly TIMEOUT_CYCLES cycles after wait entry.
    assign timeout_hit = (wait_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        grant_sel = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            grant_sel = ~last_grant;
        end
        sel_we    = grant_sel ? bus.p1_we    : bus.p0_we;
        sel_addr  = grant_sel ? bus.p1_addr  : bus.p0_addr;
        sel_size  = grant_sel ? bus.p1_size  : bus.p0_size;
        sel_wdata = grant_sel ? bus.p1_wdata : bus.p0_wdata;
    end

    // Two-flop synchronizer per strobe, plus one more flop for edge detection.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbour, which is what makes a shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= resp_async;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            last_grant            <= 1'b1;
            wait_cnt              <= '0;
            busy                  <= 1'b0;
            grant_id              <= 1'b0;
            bus.mem_read_request  <= 1'b0;
            bus.mem_write_request <= 1'b0;
            bus.mem_address       <= '0;
            bus.mem_block_size    <= '0;
            bus.mem_write_data    <= '0;
            bus.p0_ack            <= 1'b0;
            bus.p1_ack            <= 1'b0;
            bus.p0_err            <= 1'b0;
            bus.p1_err            <= 1'b0;
            bus.p0_rdata          <= '0;
            bus.p1_rdata          <= '0;
        end else begin
            // ack/err are single-cycle strobes raised only on entry to DONE.
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.p0_err <= 1'b0;
            bus.p1_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        grant_id              <= grant_sel;
                        last_grant            <= grant_sel;
                        busy                  <= 1'b1;
                        wait_cnt              <= '0;
                        bus.mem_address       <= sel_addr;
                        bus.mem_block_size    <= sel_size;
                        bus.mem_write_data    <= sel_wdata;
                        bus.mem_read_request  <= ~sel_we;
                        bus.mem_write_request <= sel_we;
                        state                 <= sel_we ? WAIT_WR_READY : WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (resp_edge[RD]) begin
                        if (grant_id) bus.p1_rdata <= bus.mem_read_data;
                        else          bus.p0_rdata <= bus.mem_read_data;
                        bus.mem_read_request <= 1'b0;
                        bus.p0_ack           <= ~grant_id;
                        bus.p1_ack           <= grant_id;
                        state                <= DONE;
                    end else if (timeout_hit) begin
                        bus.mem_read_request  <= 1'b0;
                        bus.mem_write_request <= 1'b0;
                        bus.p0_ack            <= ~grant_id;
                        bus.p1_ack            <= grant_id;
                        bus.p0_err            <= ~grant_id;
                        bus.p1_err            <= grant_id;
                        state                 <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                WAIT_WR_READY: begin
                    if (resp_edge[WR]) begin
                        wait_cnt <= '0;
                        state    <= WAIT_WR_DONE;
                    end else if (timeout_hit) begin
                        bus.mem_read_request  <= 1'b0;
                        bus.mem_write_request <= 1'b0;
                        bus.p0_ack            <= ~grant_id;
                        bus.p1_ack            <= grant_id;
                        bus.p0_err            <= ~grant_id;
                        bus.p1_err            <= grant_id;
                        state                 <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                WAIT_WR_DONE: begin
                    if (resp_edge[WF]) begin
                        bus.mem_write_request <= 1'b0;
                        bus.p0_ack            <= ~grant_id;
                        bus.p1_ack            <= grant_id;
                        state                 <= DONE;
                    end else if (timeout_hit) begin
                        bus.mem_read_request  <= 1'b0;
                        bus.mem_write_request <= 1'b0;
                        bus.p0_ack            <= ~grant_id;
                        bus.p1_ack            <= grant_id;
                        bus.p0_err            <= ~grant_id;
                        bus.p1_err            <= grant_id;
                        state                 <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                // One cycle with both requests low; new requests are looked at
                // in IDLE.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_arbiter_if bus ();
    data_memory_arbiter_if bus2 ();

    logic busy, grant_id, busy2, grant_id2;

    data_memory_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    data_memory_arbiter #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus2),
        .busy     (busy2),
        .grant_id (grant_id2)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] rd_model(input logic [63:0] addr);
        if (addr == 64'h100) return 64'hDEADBEEF;
        return {addr[31:0] ^ 32'hC0FFEE00, addr[31:0] + 32'h1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model for the main DUT: automatic responder ORed with manual pulses.
    logic auto_rr = 1'b0, auto_wr = 1'b0, auto_wf = 1'b0;
    logic man_rr = 1'b0, man_wr = 1'b0, man_wf = 1'b0;
    bit   mem_auto = 1'b0;
    int   wr_cnt = 0, wf_cnt = 0;

    assign bus.mem_read_ready     = auto_rr | man_rr;
    assign bus.mem_write_ready    = auto_wr | man_wr;
    assign bus.mem_write_finished = auto_wf | man_wf;
    assign bus.mem_read_data      = rd_model(bus.mem_address);
    assign bus2.mem_read_data     = rd_model(bus2.mem_address);

    always begin
        @(posedge clk);
        #1;
        if (mem_auto && bus.mem_read_request) begin
            #20 auto_rr = 1'b1;
            #12 auto_rr = 1'b0;
            while (bus.mem_read_request) begin @(posedge clk); #1; end
        end else if (mem_auto && bus.mem_write_request) begin
            #13 auto_wr = 1'b1; wr_cnt++;
            #12 auto_wr = 1'b0;
            #20 auto_wf = 1'b1; wf_cnt++;
            #12 auto_wf = 1'b0;
            while (bus.mem_write_request) begin @(posedge clk); #1; end
        end
    end

    // Bus monitor for the main DUT.
    int   ack0_cnt = 0, ack1_cnt = 0, rd_hi_cnt = 0, both_cnt = 0, rise_cnt = 0;
    logic prev_any = 1'b0;
    always @(negedge clk) begin
        if (bus.p0_ack === 1'b1) ack0_cnt++;
        if (bus.p1_ack === 1'b1) ack1_cnt++;
        if (bus.mem_read_request === 1'b1) rd_hi_cnt++;
        if (bus.mem_read_request === 1'b1 && bus.mem_write_request === 1'b1) both_cnt++;
        if ((bus.mem_read_request | bus.mem_write_request) === 1'b1 && !prev_any) rise_cnt++;
        prev_any = (bus.mem_read_request | bus.mem_write_request) === 1'b1;
    end

    task automatic load_port(input bit port, input bit we, input logic [63:0] addr,
                             input logic [1:0] size, input logic [63:0] wdata);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_size = size; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end else begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_size = size; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit port, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if ((port ? bus.p1_ack : bus.p0_ack) === 1'b1) ok = 1'b1;
        end
    endtask

    // Read on the short-timeout DUT; optionally answers it with a read_ready pulse.
    task automatic b2_read(input bit port, input logic [63:0] addr, input bit respond,
                           output bit acked, output int hi);
        int pulse_left;
        bit fired;
        if (port) begin bus2.p1_we = 1'b0; bus2.p1_addr = addr; bus2.p1_req = 1'b1; end
        else      begin bus2.p0_we = 1'b0; bus2.p0_addr = addr; bus2.p0_req = 1'b1; end
        acked = 1'b0; hi = 0; fired = 1'b0; pulse_left = 0;
        for (int c = 0; c < 100 && !acked; c++) begin
            @(negedge clk);
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) bus2.mem_read_ready = 1'b0;
            end
            if (bus2.mem_read_request === 1'b1) begin
                hi++;
                if (respond && !fired) begin
                    fired = 1'b1; bus2.mem_read_ready = 1'b1; pulse_left = 2;
                end
            end
            if ((bus2.p0_ack | bus2.p1_ack) === 1'b1) acked = 1'b1;
        end
        bus2.mem_read_ready = 1'b0;
        bus2.p0_req = 1'b0;
        bus2.p1_req = 1'b0;
    endtask

    initial begin
        bit ok;
        bit got;
        bit port;
        int hi;
        int b_ack0, b_ack1, b_wr, b_wf, b_rdhi, b_rise, b_both;
        int idx [2];
        bit          c_we   [2][3];
        logic [63:0] c_addr [2][3];

        reset = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_size = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_size = '0; bus.p1_wdata = '0;
        bus2.p0_req = 0; bus2.p0_we = 0; bus2.p0_addr = '0; bus2.p0_size = '0; bus2.p0_wdata = '0;
        bus2.p1_req = 0; bus2.p1_we = 0; bus2.p1_addr = '0; bus2.p1_size = '0; bus2.p1_wdata = '0;
        bus2.mem_read_ready = 0; bus2.mem_write_ready = 0; bus2.mem_write_finished = 0;

        // Reset state
        #2;
        check("rst_busy",     busy, 0);
        check("rst_grant",    grant_id, 0);
        check("rst_rd_req",   bus.mem_read_request, 0);
        check("rst_wr_req",   bus.mem_write_request, 0);
        check("rst_addr",     bus.mem_address, 0);
        check("rst_acks",     {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
        check("rst_rdata",    bus.p0_rdata | bus.p1_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single read by p0
        mem_auto = 1'b1;
        b_ack0 = ack0_cnt;
        load_port(0, 0, 64'h100, 2'b10, 64'h0);
        @(negedge clk);
        check("rd_req_up", bus.mem_read_request, 1);
        check("rd_wr_low", bus.mem_write_request, 0);
        check("rd_addr",   bus.mem_address, 64'h100);
        check("rd_size",   bus.mem_block_size, 2'b10);
        check("rd_busy",   busy, 1);
        check("rd_grant",  grant_id, 0);
        wait_ack(0, ok);
        bus.p0_req = 1'b0;
        check("rd_ack",   ok, 1);
        check("rd_data",  bus.p0_rdata, 64'hDEADBEEF);
        check("rd_err",   bus.p0_err, 0);
        check("rd_req_dn", bus.mem_read_request, 0);
        repeat (3) @(negedge clk);
        check("rd_ack_once", ack0_cnt - b_ack0, 1);
        check("rd_idle", busy, 0);

        // Single write by p1
        b_ack1 = ack1_cnt; b_wr = wr_cnt; b_wf = wf_cnt; b_rdhi = rd_hi_cnt;
        load_port(1, 1, 64'h40, 2'b11, 64'h55AA);
        @(negedge clk);
        check("wr_req_up", bus.mem_write_request, 1);
        check("wr_addr",   bus.mem_address, 64'h40);
        check("wr_size",   bus.mem_block_size, 2'b11);
        check("wr_data",   bus.mem_write_data, 64'h55AA);
        check("wr_grant",  grant_id, 1);
        wait_ack(1, ok);
        bus.p1_req = 1'b0;
        check("wr_ack",        ok, 1);
        check("wr_ready_seen", wr_cnt - b_wr, 1);
        check("wr_fin_before", wf_cnt - b_wf, 1);
        check("wr_err",        bus.p1_err, 0);
        check("wr_p0_quiet",   bus.p0_ack, 0);
        repeat (3) @(negedge clk);
        check("wr_ack_once",   ack1_cnt - b_ack1, 1);
        check("wr_no_read",    rd_hi_cnt - b_rdhi, 0);

        // Contention straight after reset: grant order 0,1,0,1,0,1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        c_we[0][0] = 0; c_addr[0][0] = 64'h1000;
        c_we[0][1] = 1; c_addr[0][1] = 64'h1008;
        c_we[0][2] = 0; c_addr[0][2] = 64'h1010;
        c_we[1][0] = 1; c_addr[1][0] = 64'h2000;
        c_we[1][1] = 0; c_addr[1][1] = 64'h2008;
        c_we[1][2] = 0; c_addr[1][2] = 64'h2010;
        idx[0] = 0; idx[1] = 0;
        b_rise = rise_cnt; b_both = both_cnt;
        load_port(0, c_we[0][0], c_addr[0][0], 2'b01, c_addr[0][0] ^ 64'hFF);
        load_port(1, c_we[1][0], c_addr[1][0], 2'b01, c_addr[1][0] ^ 64'hFF);
        for (int i = 0; i < 6; i++) begin
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if ((bus.p0_ack | bus.p1_ack) === 1'b1) got = 1'b1;
            end
            check("cont_ack", got, 1);
            if (!got) break;
            port = bus.p1_ack;
            check("cont_order", port, i % 2);
            check("cont_grant", grant_id, port);
            check("cont_err", port ? bus.p1_err : bus.p0_err, 0);
            if (!c_we[port][idx[port]])
                check("cont_rdata", port ? bus.p1_rdata : bus.p0_rdata, rd_model(c_addr[port][idx[port]]));
            idx[port]++;
            if (idx[port] < 3)
                load_port(port, c_we[port][idx[port]], c_addr[port][idx[port]], 2'b01,
                          c_addr[port][idx[port]] ^ 64'hFF);
            else if (port) bus.p1_req = 1'b0;
            else           bus.p0_req = 1'b0;
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        repeat (3) @(negedge clk);
        check("cont_gaps",    rise_cnt - b_rise, 6);
        check("cont_no_both", both_cnt - b_both, 0);

        // Stray write_ready while waiting on a read
        mem_auto = 1'b0;
        b_ack0 = ack0_cnt;
        load_port(0, 0, 64'h300, 2'b00, 64'h0);
        @(negedge clk);
        check("stray_rd_up", bus.mem_read_request, 1);
        man_wr = 1'b1; #12 man_wr = 1'b0;
        repeat (6) @(negedge clk);
        check("stray_busy",   busy, 1);
        check("stray_rd_hold", bus.mem_read_request, 1);
        check("stray_no_wr",  bus.mem_write_request, 0);
        check("stray_no_ack", ack0_cnt - b_ack0, 0);
        man_rr = 1'b1; #12 man_rr = 1'b0;
        wait_ack(0, ok);
        bus.p0_req = 1'b0;
        check("stray_ack",   ok, 1);
        check("stray_rdata", bus.p0_rdata, rd_model(64'h300));
        check("stray_err",   bus.p0_err, 0);

        // Reset asserted in WAIT_WR_DONE
        @(negedge clk);
        b_ack1 = ack1_cnt;
        load_port(1, 1, 64'h80, 2'b01, 64'h1234);
        @(negedge clk);
        check("rstop_wr_up", bus.mem_write_request, 1);
        man_wr = 1'b1; #12 man_wr = 1'b0;
        repeat (5) @(negedge clk);
        check("rstop_in_wrdone", bus.mem_write_request, 1);
        check("rstop_no_early_ack", ack1_cnt - b_ack1, 0);
        #2 reset = 1'b1;
        #1;
        check("rstop_wr_req", bus.mem_write_request, 0);
        check("rstop_busy",   busy, 0);
        check("rstop_grant",  grant_id, 0);
        check("rstop_addr",   bus.mem_address, 0);
        check("rstop_wdata",  bus.mem_write_data, 0);
        bus.p1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        man_wf = 1'b1; #12 man_wf = 1'b0;
        repeat (6) @(negedge clk);
        check("rstop_no_ack", ack1_cnt - b_ack1, 0);
        check("rstop_idle",   busy, 0);
        mem_auto = 1'b1;
        load_port(0, 0, 64'h500, 2'b10, 64'h0);
        wait_ack(0, ok);
        bus.p0_req = 1'b0;
        check("rstop_rd_ack",   ok, 1);
        check("rstop_rd_rdata", bus.p0_rdata, rd_model(64'h500));
        check("rstop_rd_err",   bus.p0_err, 0);

        // Timeout on the TIMEOUT_CYCLES=8 instance
        @(negedge clk);
        b2_read(0, 64'h10, 1, ok, hi);
        check("to_pre_ack",   ok, 1);
        check("to_pre_rdata", bus2.p0_rdata, rd_model(64'h10));
        check("to_pre_err",   bus2.p0_err, 0);
        @(negedge clk);
        b2_read(0, 64'h20, 0, ok, hi);
        check("to_ack",    ok, 1);
        check("to_port",   bus2.p0_ack, 1);
        check("to_err",    bus2.p0_err, 1);
        check("to_cycles", hi, 8);
        check("to_rdata_kept", bus2.p0_rdata, rd_model(64'h10));
        check("to_req_dn", bus2.mem_read_request, 0);
        @(negedge clk);
        b2_read(1, 64'h30, 1, ok, hi);
        check("post_to_ack",   ok, 1);
        check("post_to_port",  bus2.p1_ack, 1);
        check("post_to_err",   bus2.p1_err, 0);
        check("post_to_rdata", bus2.p1_rdata, rd_model(64'h30));
        check("post_to_grant", grant_id2, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
